// File: rtl/mem_bist_pkg.sv
// Shared types for the March C- memory BIST: FSM states and the march element table.
package mem_bist_pkg;

    localparam int unsigned NUM_ELEM = 6;
    localparam int unsigned ELEM_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // One memory operation: write or read, with data bit 0 = background, 1 = inverted.
    typedef struct packed {
        logic is_wr;
        logic dbit;
    } march_op_t;

    // One march element: traversal direction, 1 or 2 ops per word, ops[0] issued first.
    typedef struct packed {
        logic            down;
        logic [1:0]      nops;
        march_op_t [1:0] ops;
    } march_elem_t;

    localparam march_op_t OP_NONE = '{is_wr: 1'b0, dbit: 1'b0};
    localparam march_op_t OP_R0   = '{is_wr: 1'b0, dbit: 1'b0};
    localparam march_op_t OP_R1   = '{is_wr: 1'b0, dbit: 1'b1};
    localparam march_op_t OP_W0   = '{is_wr: 1'b1, dbit: 1'b0};
    localparam march_op_t OP_W1   = '{is_wr: 1'b1, dbit: 1'b1};

    // March C-: up(w0) up(r0,w1) up(r1,w0) down(r0,w1) down(r1,w0) up(r0)
    function automatic march_elem_t march_elem(input logic [ELEM_W-1:0] idx);
        march_elem_t e;
        e = '0;
        case (idx)
            3'd0: e = '{down: 1'b0, nops: 2'd1, ops: {OP_NONE, OP_W0}};
            3'd1: e = '{down: 1'b0, nops: 2'd2, ops: {OP_W1, OP_R0}};
            3'd2: e = '{down: 1'b0, nops: 2'd2, ops: {OP_W0, OP_R1}};
            3'd3: e = '{down: 1'b1, nops: 2'd2, ops: {OP_W1, OP_R0}};
            3'd4: e = '{down: 1'b1, nops: 2'd2, ops: {OP_W0, OP_R1}};
            3'd5: e = '{down: 1'b0, nops: 2'd1, ops: {OP_NONE, OP_R0}};
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/mem_bist_addr_gen.sv
// Word address counter for the BIST: loadable, counts up or down, flags the last word
// of the current traversal direction.
module mem_bist_addr_gen #(
    parameter int unsigned NUM_WORDS = 8192,
    parameter int unsigned WORD_W    = 13
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [WORD_W-1:0] load_val_i,
    input  logic              en_i,
    input  logic              down_i,
    output logic [WORD_W-1:0] word_o,
    output logic              last_c
);

    localparam logic [WORD_W-1:0] LAST_UP = WORD_W'(NUM_WORDS - 1);

    // Load wins over count; the element-end load stops a down count from wrapping into use.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            word_o <= '0;
        end else if (load_i) begin
            word_o <= load_val_i;
        end else if (en_i) begin
            word_o <= down_i ? (word_o - WORD_W'(1)) : (word_o + WORD_W'(1));
        end
    end

    assign last_c = down_i ? (word_o == '0) : (word_o == LAST_UP);

endmodule

// File: rtl/mem_bist_ctrl.sv
// March C- BIST initiator for a single-port RAM: one access per cycle, read data checked
// one cycle after each read, first failure captured and reported.
module mem_bist_ctrl #(
    parameter int unsigned           ADDR_WIDTH = 15,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           NUM_WORDS  = 8192,
    parameter logic [DATA_WIDTH-1:0] BG_PATTERN = '0
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic [DATA_WIDTH-1:0] fail_data_o,
    output logic [DATA_WIDTH-1:0] fail_exp_o,
    output logic                  mem_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  mem_bypass_o
);
    import mem_bist_pkg::*;

    localparam int unsigned       WORD_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(NUM_WORDS - 1);

    state_t              state_q;
    logic [ELEM_W-1:0]   elem_q;
    logic                op_q;

    // Read pipeline: stage rd_* travels with the read access, stage chk_* lines up with rdata.
    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_exp_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic                  chk_valid_q;
    logic [DATA_WIDTH-1:0] chk_exp_q;
    logic [ADDR_WIDTH-1:0] chk_addr_q;

    logic [WORD_W-1:0]     word;
    logic                  last_word;

    march_elem_t           cur_elem;
    march_elem_t           nxt_elem;
    march_op_t             cur_op;
    logic [ELEM_W-1:0]     nxt_idx;
    logic                  last_op;
    logic                  elem_end;
    logic                  final_acc;
    logic                  mismatch;
    logic                  abort;
    logic                  issue;
    logic                  stay_drain;
    logic                  ag_load;
    logic                  ag_en;
    logic [WORD_W-1:0]     ag_val;
    logic [DATA_WIDTH-1:0] acc_data;
    logic [ADDR_WIDTH-1:0] acc_addr;

    mem_bist_addr_gen #(
        .NUM_WORDS (NUM_WORDS),
        .WORD_W    (WORD_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst_i      (rst_i),
        .load_i     (ag_load),
        .load_val_i (ag_val),
        .en_i       (ag_en),
        .down_i     (cur_elem.down),
        .word_o     (word),
        .last_c     (last_word)
    );

    // Pointer (elem_q, op_q, word) always names the next access to issue.
    always_comb begin
        cur_elem   = march_elem(elem_q);
        cur_op     = cur_elem.ops[op_q];
        last_op    = (cur_elem.nops != 2'd2) || op_q;
        elem_end   = last_op && last_word;
        final_acc  = elem_end && (elem_q == ELEM_W'(NUM_ELEM - 1));
        nxt_idx    = final_acc ? '0 : (elem_q + ELEM_W'(1));
        nxt_elem   = march_elem(nxt_idx);
        mismatch   = chk_valid_q && (mem_rdata_i != chk_exp_q);
        abort      = mismatch && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
        issue      = ((state_q == ST_RUN) && !mismatch) ||
                     (((state_q == ST_IDLE) || (state_q == ST_DONE)) && start_i);
        stay_drain = (state_q == ST_DRAIN) && !mismatch && rd_valid_q;
        ag_load    = (issue && elem_end) || abort;
        ag_val     = (abort || !nxt_elem.down) ? '0 : LAST_WORD;
        ag_en      = issue && last_op && !last_word;
        acc_data   = cur_op.dbit ? ~BG_PATTERN : BG_PATTERN;
        acc_addr   = ADDR_WIDTH'({word, 2'b00});
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            elem_q      <= '0;
            op_q        <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_exp_q    <= '0;
            rd_addr_q   <= '0;
            chk_valid_q <= 1'b0;
            chk_exp_q   <= '0;
            chk_addr_q  <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            pass_o      <= 1'b0;
            fail_addr_o <= '0;
            fail_data_o <= '0;
            fail_exp_o  <= '0;
            mem_en_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= 4'h0;
            mem_wdata_o <= '0;
        end else begin
            chk_valid_q <= rd_valid_q;
            chk_exp_q   <= rd_exp_q;
            chk_addr_q  <= rd_addr_q;

            if (issue) begin
                mem_en_o    <= 1'b1;
                mem_we_o    <= cur_op.is_wr;
                mem_be_o    <= 4'hF;
                mem_addr_o  <= acc_addr;
                mem_wdata_o <= cur_op.is_wr ? acc_data : '0;
                rd_valid_q  <= !cur_op.is_wr;
                rd_exp_q    <= acc_data;
                rd_addr_q   <= acc_addr;
                op_q        <= !last_op;
                if (elem_end) begin
                    elem_q <= nxt_idx;
                end
            end else begin
                mem_en_o    <= 1'b0;
                mem_we_o    <= 1'b0;
                mem_be_o    <= stay_drain ? 4'hF : 4'h0;
                mem_wdata_o <= '0;
                rd_valid_q  <= 1'b0;
            end

            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        state_q     <= ST_RUN;
                        busy_o      <= 1'b1;
                        done_o      <= 1'b0;
                        pass_o      <= 1'b0;
                        fail_addr_o <= '0;
                        fail_data_o <= '0;
                        fail_exp_o  <= '0;
                    end
                end
                ST_RUN: begin
                    if (final_acc && !mismatch) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!mismatch && !rd_valid_q) begin
                        state_q <= ST_DONE;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                        pass_o  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // First mismatch ends the test; in-flight accesses are dropped.
            if (abort) begin
                state_q     <= ST_DONE;
                busy_o      <= 1'b0;
                done_o      <= 1'b1;
                pass_o      <= 1'b0;
                fail_addr_o <= chk_addr_q;
                fail_data_o <= mem_rdata_i;
                fail_exp_o  <= chk_exp_q;
                elem_q      <= '0;
                op_q        <= 1'b0;
                rd_valid_q  <= 1'b0;
                chk_valid_q <= 1'b0;
            end
        end
    end

    assign mem_bypass_o = 1'b0;

endmodule
